// File: rtl/aud_dac_serializer.sv
// Stereo I2S / left-justified DAC serializer with a one-deep frame buffer.
// All state advances on the falling edge of the codec bit clock.
module aud_dac_serializer #(
    parameter int DATA_W    = 16,
    parameter int MODE      = 0,
    parameter int HOLD_LAST = 1
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_en,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data_l,
    input  logic [DATA_W-1:0] i_data_r,
    output logic              o_aud_dacdat,
    output logic              o_underrun
);
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_WAIT, S_DELAY, S_SHIFT, S_PAD} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              lrck_q, primed_q;
    logic              full_q, full_d;
    logic              slot_r_q, slot_r_d;
    logic [DATA_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DATA_W-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
    logic              dat_q, dat_d;
    logic              und_q, und_d;
    logic              edge_det, left_start, accept;
    logic [DATA_W-1:0] word_edge, word_cur;

    // The first cycle after reset only primes lrck_q, so no edge is seen then.
    assign edge_det   = primed_q && (i_daclrck != lrck_q);
    assign left_start = edge_det && !i_daclrck;
    assign accept     = i_valid && !full_q;

    always_comb begin
        full_d  = full_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        frm_l_d = frm_l_q;
        frm_r_d = frm_r_q;
        und_d   = 1'b0;
        if (left_start) begin
            if (!i_en) begin
                frm_l_d = '0;
                frm_r_d = '0;
            end else if (full_q) begin
                frm_l_d = buf_l_q;
                frm_r_d = buf_r_q;
                full_d  = 1'b0;
            end else begin
                und_d = 1'b1;
                if (HOLD_LAST == 0) begin
                    frm_l_d = '0;
                    frm_r_d = '0;
                end
            end
        end
        // A frame accepted on an underrunning left start waits for the next one.
        if (accept) begin
            buf_l_d = i_data_l;
            buf_r_d = i_data_r;
            full_d  = 1'b1;
        end
    end

    assign word_edge = i_daclrck ? frm_r_d : frm_l_d;
    assign word_cur  = slot_r_q ? frm_r_q : frm_l_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        slot_r_d = slot_r_q;
        dat_d    = 1'b0;
        if (edge_det) begin
            slot_r_d = i_daclrck;
            if (MODE == 0) begin
                state_d = S_DELAY;
            end else begin
                dat_d   = word_edge[DATA_W-1];
                idx_d   = IDX_W'(DATA_W - 2);
                state_d = S_SHIFT;
            end
        end else begin
            case (state_q)
                S_DELAY: begin
                    dat_d   = word_cur[DATA_W-1];
                    idx_d   = IDX_W'(DATA_W - 2);
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    dat_d = word_cur[idx_q];
                    if (idx_q == '0) begin
                        state_d = S_PAD;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                default: dat_d = 1'b0;
            endcase
        end
    end

    always_ff @(negedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_WAIT;
            idx_q    <= '0;
            lrck_q   <= 1'b0;
            primed_q <= 1'b0;
            full_q   <= 1'b0;
            slot_r_q <= 1'b0;
            buf_l_q  <= '0;
            buf_r_q  <= '0;
            frm_l_q  <= '0;
            frm_r_q  <= '0;
            dat_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lrck_q   <= i_daclrck;
            primed_q <= 1'b1;
            full_q   <= full_d;
            slot_r_q <= slot_r_d;
            buf_l_q  <= buf_l_d;
            buf_r_q  <= buf_r_d;
            frm_l_q  <= frm_l_d;
            frm_r_q  <= frm_r_d;
            dat_q    <= dat_d;
            und_q    <= und_d;
        end
    end

    assign o_ready      = !full_q;
    assign o_aud_dacdat = dat_q;
    assign o_underrun   = und_q;
endmodule

// File: tb/tb_aud_dac_serializer.sv
// Scoreboard bench: two serializers (I2S/hold-last and left-justified/zero-fill)
// share stimulus; a monitor captures each LRCK slot and checks it against the queue.
module tb_aud_dac_serializer;
    logic        bclk;
    logic        rst_n;
    logic        daclrck;
    logic        en;
    logic        valid;
    logic [15:0] data_l;
    logic [15:0] data_r;
    logic        ready_a, ready_b;
    logic        dat_a, dat_b;
    logic        und_a, und_b;

    aud_dac_serializer #(.DATA_W(16), .MODE(0), .HOLD_LAST(1)) dut_a (
        .i_bclk(bclk), .i_rst_n(rst_n), .i_daclrck(daclrck), .i_en(en),
        .i_valid(valid), .o_ready(ready_a), .i_data_l(data_l), .i_data_r(data_r),
        .o_aud_dacdat(dat_a), .o_underrun(und_a)
    );

    aud_dac_serializer #(.DATA_W(16), .MODE(1), .HOLD_LAST(0)) dut_b (
        .i_bclk(bclk), .i_rst_n(rst_n), .i_daclrck(daclrck), .i_en(en),
        .i_valid(valid), .o_ready(ready_b), .i_data_l(data_l), .i_data_r(data_r),
        .o_aud_dacdat(dat_b), .o_underrun(und_b)
    );

    typedef struct packed {
        logic [63:0] pa;
        logic [63:0] pb;
        logic [7:0]  len;
        logic [1:0]  ua;
        logic [1:0]  ub;
        logic [7:0]  id;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          slot_id  = 0;
    bit          mon_on   = 0;
    bit          drop_valid = 0;
    logic        lr_neg, lr_prev;
    logic [63:0] sa, sb;
    int          nb, ca, cb;
    bit          in_slot = 0;

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Expected serial slot, first transmitted bit in position len-1.
    function automatic logic [63:0] pat(input logic [15:0] w, input int mode, input int len);
        logic [63:0] p;
        int          j;
        logic        b;
        p = '0;
        for (int i = 0; i < len; i++) begin
            j = (mode == 0) ? i - 1 : i;
            b = (j >= 0 && j < 16) ? w[15-j] : 1'b0;
            p = {p[62:0], b};
        end
        return p;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge bclk);
            #2;
            if (drop_valid) begin
                valid      = 1'b0;
                drop_valid = 1'b0;
            end
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        chk("push_ready_a", {63'd0, ready_a}, 64'd1);
        chk("push_ready_b", {63'd0, ready_b}, 64'd1);
        data_l     = l;
        data_r     = r;
        valid      = 1'b1;
        drop_valid = 1'b1;
    endtask

    task automatic begin_slot(input logic lv, input int len, input logic [15:0] wa,
                              input logic [15:0] wb, input int ua, input int ub);
        exp_t e;
        e.pa  = pat(wa, 0, len);
        e.pb  = pat(wb, 1, len);
        e.len = 8'(len);
        e.ua  = 2'(ua);
        e.ub  = 2'(ub);
        e.id  = 8'(slot_id);
        slot_id++;
        exp_q.push_back(e);
        daclrck = lv;
    endtask

    task automatic slot(input logic lv, input int len, input logic [15:0] wa,
                        input logic [15:0] wb, input int ua, input int ub);
        begin_slot(lv, len, wa, wb, ua, ub);
        tick(len);
    endtask

    task automatic finish_slot();
        exp_t        e;
        logic [63:0] mask;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_unexpected_slot: got slot with %0d bits, required none", nb);
        end else begin
            e    = exp_q.pop_front();
            mask = (64'd1 << e.len) - 64'd1;
            chk($sformatf("slot%0d_len", e.id), 64'(nb), 64'(e.len));
            chk($sformatf("slot%0d_dat_a", e.id), sa & mask, e.pa);
            chk($sformatf("slot%0d_dat_b", e.id), sb & mask, e.pb);
            chk($sformatf("slot%0d_und_a", e.id), 64'(ca), 64'(e.ua));
            chk($sformatf("slot%0d_und_b", e.id), 64'(cb), 64'(e.ub));
            $display("slot %0d: len=%0d a=%h b=%h und=%0d/%0d", e.id, nb, sa & mask, sb & mask, ca, cb);
        end
    endtask

    // Copy of LRCK as the DUT samples it on each falling edge.
    initial begin
        lr_neg  = 1'b1;
        lr_prev = 1'b1;
        forever begin
            @(negedge bclk);
            lr_prev = lr_neg;
            lr_neg  = daclrck;
        end
    end

    initial begin
        forever begin
            @(posedge bclk);
            if (!mon_on) begin
                in_slot = 0;
            end else begin
                if (lr_neg != lr_prev) begin
                    if (in_slot) finish_slot();
                    in_slot = 1;
                    nb = 0; sa = '0; sb = '0; ca = 0; cb = 0;
                end
                if (in_slot) begin
                    sa = {sa[62:0], dat_a};
                    sb = {sb[62:0], dat_b};
                    nb++;
                    ca += int'(und_a);
                    cb += int'(und_b);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; daclrck = 1'b1; en = 1'b1; valid = 1'b0;
        data_l = '0; data_r = '0;
        tick(2);
        chk("rst_dat_a", {63'd0, dat_a}, 64'd0);
        chk("rst_dat_b", {63'd0, dat_b}, 64'd0);
        chk("rst_ready_a", {63'd0, ready_a}, 64'd1);
        chk("rst_ready_b", {63'd0, ready_b}, 64'd1);
        chk("rst_und_a", {63'd0, und_a}, 64'd0);
        rst_n = 1'b1;
        tick(2);
        push(16'hA5C3, 16'h0F0F);
        tick(3);
        mon_on = 1;

        slot(1'b0, 32, 16'hA5C3, 16'hA5C3, 0, 0);
        slot(1'b1, 32, 16'h0F0F, 16'h0F0F, 0, 0);
        slot(1'b0, 32, 16'hA5C3, 16'h0000, 1, 1);
        slot(1'b1, 32, 16'h0F0F, 16'h0000, 0, 0);
        push(16'h1234, 16'h5678);
        slot(1'b0, 32, 16'hA5C3, 16'h0000, 1, 1);
        slot(1'b1, 32, 16'h0F0F, 16'h0000, 0, 0);
        slot(1'b0, 32, 16'h1234, 16'h1234, 0, 0);

        begin_slot(1'b1, 32, 16'h5678, 16'h5678, 0, 0);
        tick(4);
        valid = 1'b1; data_l = 16'h1111; data_r = 16'h2222;
        tick(1);
        data_l = 16'h3333; data_r = 16'h4444;
        tick(26);
        chk("bp_ready_low", {63'd0, ready_a}, 64'd0);
        tick(1);
        begin_slot(1'b0, 32, 16'h1111, 16'h1111, 0, 0);
        tick(1);
        chk("bp_ready_back", {63'd0, ready_a}, 64'd1);
        tick(1);
        chk("bp_second_accept", {63'd0, ready_a}, 64'd0);
        valid = 1'b0;
        tick(30);
        slot(1'b1, 32, 16'h2222, 16'h2222, 0, 0);
        slot(1'b0, 32, 16'h3333, 16'h3333, 0, 0);
        push(16'hA5C3, 16'h0F0F);
        slot(1'b1, 32, 16'h4444, 16'h4444, 0, 0);

        slot(1'b0, 8, 16'hA5C3, 16'hA5C3, 0, 0);
        slot(1'b1, 8, 16'h0F0F, 16'h0F0F, 0, 0);
        slot(1'b0, 8, 16'hA5C3, 16'h0000, 1, 1);
        push(16'hBEEF, 16'hCAFE);
        slot(1'b1, 32, 16'h0F0F, 16'h0000, 0, 0);

        en = 1'b0;
        begin_slot(1'b0, 32, 16'h0000, 16'h0000, 0, 0);
        tick(16);
        chk("en0_buffer_kept", {63'd0, ready_a}, 64'd0);
        tick(16);
        slot(1'b1, 32, 16'h0000, 16'h0000, 0, 0);
        en = 1'b1;
        slot(1'b0, 32, 16'hBEEF, 16'hBEEF, 0, 0);
        push(16'hABCD, 16'h1357);
        slot(1'b1, 32, 16'hCAFE, 16'hCAFE, 0, 0);

        daclrck = 1'b0;
        tick(2);
        push(16'h7777, 16'h8888);
        tick(4);
        chk("pre_reset_dat_a", {63'd0, dat_a}, 64'd1);
        chk("pre_reset_ready_a", {63'd0, ready_a}, 64'd0);
        mon_on = 0;
        rst_n  = 1'b0;
        #1;
        chk("async_rst_dat_a", {63'd0, dat_a}, 64'd0);
        chk("async_rst_ready_a", {63'd0, ready_a}, 64'd1);
        chk("async_rst_ready_b", {63'd0, ready_b}, 64'd1);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        push(16'h7E81, 16'h0180);
        tick(2);
        mon_on = 1;
        slot(1'b1, 32, 16'h0000, 16'h0000, 0, 0);
        slot(1'b0, 32, 16'h7E81, 16'h7E81, 0, 0);
        slot(1'b1, 32, 16'h0180, 16'h0180, 0, 0);
        daclrck = 1'b0;
        tick(4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/aud_dac_serializer.md
# aud_dac_serializer

Parametrised stereo I2S/left-justified DAC serializer. It is the successor to the single-channel, fixed-16-bit audio player path, and sits between the sample source (recorder/playback controller) and the codec DAC data pin. It accepts stereo frames through a valid/ready handshake into a one-deep buffer. It serializes left and right words MSB-first, aligned to the codec-driven LR clock. Buffer underruns are flagged.

## Interface
Parameters:
- DATA_W, 16: sample width per channel; legal range 8..32.
- MODE, 0: 0 = I2S (one BCLK delay slot after each LRCK edge); 1 = left-justified (MSB in first bit after the edge).
- HOLD_LAST, 1: on underrun, 1 = replay the previous frame; 0 = send zeros.

Ports:
- i_bclk  in  1  bit clock from codec; the only clock; all state updates on its falling edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_daclrck  in  1  codec LR clock, synchronous to i_bclk; low = left slot, high = right slot.
- i_en  in  1  playback enable, sampled at left-slot start.
- i_valid  in  1  frame on i_data_l/i_data_r is valid.
- o_ready  out  1  buffer empty; a frame is accepted on a falling edge with i_valid && o_ready.
- i_data_l  in  DATA_W  left sample, two's complement.
- i_data_r  in  DATA_W  right sample, two's complement.
- o_aud_dacdat  out  1  serial DAC data, registered.
- o_underrun  out  1  one-cycle pulse when a left slot starts with an empty buffer while i_en=1.

## Operation
- **Reset values:** o_aud_dacdat=0, o_ready=1, o_underrun=0. Buffer is empty. Frame registers (L/R) are 0. The primed flag is 0. State is S_WAIT.
- **LRCK edge detection:** lrck_d is a registered copy of i_daclrck. On the first falling edge after reset, the block only loads lrck_d and sets primed; no edge is detected on that cycle. After that, edge = primed && (i_daclrck != lrck_d).
- **Left start:** i_daclrck falls (1→0).
  - If i_en=0: frame registers are loaded with zeros. The buffer is untouched and no underrun is raised.
  - If i_en=1 and the buffer is full: buffer moves to the frame registers and the buffer empties.
  - If i_en=1 and the buffer is empty: o_underrun pulses. Frame registers keep their value (HOLD_LAST=1) or clear to 0 (HOLD_LAST=0).
- **Right start:** i_daclrck rises (0→1). The right word comes from the frame registers loaded at the preceding left start. This is zero before the first left start.
- **Per-slot FSM:**
  - S_WAIT: o_aud_dacdat=0 until the first detected edge.
  - Any edge: go to S_DELAY if MODE=0, or S_SHIFT with bit index DATA_W-1 if MODE=1.
  - S_DELAY: drive 0 for one cycle, then go to S_SHIFT with index DATA_W-1.
  - S_SHIFT: drive word[index] and decrement; after index 0 go to S_PAD.
  - S_PAD: drive 0 until the next edge.
- **Edge precedence:** an edge in any state restarts the FSM for the new slot. Unfinished bits of a too-short slot are dropped, with no error and no hang.
- **Handshake:**
  - o_ready = buffer empty, registered.
  - Accepting a frame sets o_ready=0 on the same edge.
  - A left-start transfer sets o_ready=1 on the same edge.
- **Simultaneous events:**
  - A left start with an empty buffer and i_valid=1 in the same cycle is an underrun. The frame is accepted into the buffer and used at the next left start (no bypass).
  - A buffer-full transfer and an accept never coincide, because o_ready=0 then.
- **Bit counter width:** $clog2(DATA_W). No arithmetic is applied to sample data.

## Timing
- Edge detection, the frame transfer and the first output decision all occur on the falling edge N on which the new i_daclrck level is first sampled.
- MODE=0: o_aud_dacdat=0 after edge N, MSB after N+1, LSB after N+DATA_W, then 0.
- MODE=1: MSB after edge N, LSB after N+DATA_W-1.
- Accept-to-air latency: the accepted frame goes out starting at the next left start. Worst case is one LRCK period plus the delay slot.
- o_underrun is high for exactly the cycle following edge N.
- Asserting i_rst_n mid-slot clears all state immediately (asynchronously). After release, one priming cycle occurs, then output resumes at the first detected edge.

## Test plan
- **I2S baseline:** DATA_W=16, MODE=0, 32 BCLK per slot. Push L=16'hA5C3, R=16'h0F0F before the first LRCK fall → left slot is 0, 1010010111000011, then 15 zeros. Right slot is 0, 0000111100001111, then 15 zeros. o_underrun stays 0.
- **Left-justified:** MODE=1, same frame → MSB 1 in the first bit after the LRCK fall, 16 data bits, then 16 zeros. Right slot is 0000111100001111 followed by zeros.
- **Underrun:** send frame 1, then no push before the second left start → o_underrun high for one cycle at that edge.
  - HOLD_LAST=1: A5C3/0F0F are replayed.
  - HOLD_LAST=0: all-zero slots.
- **Backpressure:** hold i_valid=1 with frames 1111/2222, 3333/4444 → only the first is accepted. o_ready stays 0 until the next left start, returns to 1 on that edge, and the second frame is accepted on the following edge and plays one frame later.
- **Short slot:** 8 BCLK per slot, DATA_W=16, MODE=0, L=16'hA5C3 → 0 followed by 1010010. The next edge restarts cleanly with no stall.
- **Reset and disable:**
  - Pull i_rst_n low mid-shift → o_aud_dacdat=0 and o_ready=1 immediately. After release, a pushed frame plays correctly from the next left start.
  - With i_en=0 at a left start → zero slots, no underrun, buffer retained.
